// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle sequencer for the MIPS-subset datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB, decodes the IR into per-state control
// words, and handles im/dm wait states with an optional timeout.
// Optional build: define MULTI_CYCLE_CONTROL_PERF_EN to add the
// perf_cycles / perf_retired counters.
module multi_cycle_control #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 0,
  parameter int TMO_CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                im_ready,
  input  logic                dm_ready,
  input  logic                alu_zero,
  output logic [2:0]          state,
  output logic                im_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          npc_mode,
  output logic                rf_we,
  output logic                rf_waddr_sel,
  output logic                rf_wdata_sel,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          ext_mode,
  output logic                dm_req,
  output logic                dm_we,
  output logic                illegal_instr,
  output logic                bus_error
`ifdef MULTI_CYCLE_CONTROL_PERF_EN
  ,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_retired
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(2);

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_PAD  = 2'd2;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;

  logic [2:0]           state_d;
  logic [TMO_CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic                 tmo;

  // Instruction decode; only the fields of the supported subset matter.
  logic [5:0] op, fn;
  logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_nop;
  logic is_legal;

  assign op       = instr[31:26];
  assign fn       = instr[5:0];
  assign is_nop   = (instr == 32'h0);
  assign is_addu  = (op == 6'h00) && (fn == 6'h21);
  assign is_subu  = (op == 6'h00) && (fn == 6'h23);
  assign is_ori   = (op == 6'h0D);
  assign is_lui   = (op == 6'h0F);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_beq   = (op == 6'h04);
  assign is_j     = (op == 6'h02);
  assign is_legal = is_nop | is_addu | is_subu | is_ori | is_lui |
                    is_lw | is_sw | is_beq | is_j;

  // Wait counter saturates; a timeout only exists when MEM_TIMEOUT is nonzero.
  assign cnt_inc = (cnt == {TMO_CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  assign tmo     = (MEM_TIMEOUT != 0) && (cnt == TMO_CNT_W'(MEM_TIMEOUT));

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Datapath operand/ALU selection, held from EXEC through MEM and WB.
  always_comb begin
    alu_src  = 1'b0;
    alu_op   = ALU_ADD;
    ext_mode = EXT_ZERO;
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      if (is_subu || is_beq) begin
        alu_op = ALU_SUB;
      end else if (is_ori) begin
        alu_src = 1'b1;
        alu_op  = ALU_OR;
      end else if (is_lui) begin
        alu_src  = 1'b1;
        alu_op   = ALU_OR;
        ext_mode = EXT_PAD;
      end else if (is_lw || is_sw) begin
        alu_src  = 1'b1;
        ext_mode = EXT_SIGN;
      end
    end
  end

  // Next state, strobes and wait counter update. The counter is zero in
  // every state except while a request is waiting, so entry to FETCH/MEM
  // always sees a cleared counter.
  always_comb begin
    state_d       = state;
    cnt_d         = '0;
    im_req        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    npc_mode      = NPC_SEQ;
    rf_we         = 1'b0;
    rf_waddr_sel  = 1'b0;
    rf_wdata_sel  = 1'b0;
    dm_req        = 1'b0;
    dm_we         = 1'b0;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    case (state)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        im_req = 1'b1;
        if (im_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo) begin
          bus_error = 1'b1;           // retry with a fresh counter
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DECODE: begin
        if (is_j) begin
          pc_write = 1'b1;
          npc_mode = NPC_J;
          state_d  = S_FETCH;
        end else if (is_nop) begin
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else if (!is_legal) begin
          illegal_instr = 1'b1;
          pc_write      = 1'b1;
          state_d       = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          pc_write = 1'b1;
          npc_mode = alu_zero ? NPC_BR : NPC_SEQ;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = is_sw;
        if (dm_ready) begin
          if (is_sw) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo) begin
          bus_error = 1'b1;           // abandon access, skip any RF write
          pc_write  = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB: begin
        rf_we        = 1'b1;
        pc_write     = 1'b1;
        rf_waddr_sel = is_addu | is_subu;
        rf_wdata_sel = is_lw;
        state_d      = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MULTI_CYCLE_CONTROL_PERF_EN
  // Free-running activity counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else begin
      if (state != S_IDLE)
        perf_cycles <= perf_cycles + 32'd1;
      if (pc_write && !illegal_instr && !bus_error)
        perf_retired <= perf_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: two instances (MEM_TIMEOUT=0 and 4) with
// independent inputs; each instruction is walked through the phases the
// ISA rules dictate and every output is compared cycle by cycle.
module tb_multi_cycle_control;

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_NOP, K_ILL} kind_t;

  typedef struct packed {
    logic [2:0] st;
    logic       im_req, ir_write, pcw;
    logic [1:0] npc;
    logic       rf_we, waddr, wdata, alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext;
    logic       dm_req, dm_we, ill, berr;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr [2];
  logic        im_ready [2], dm_ready [2], alu_zero [2];
  logic [2:0]  state [2];
  logic        im_req [2], ir_write [2], pc_write [2];
  logic [1:0]  npc_mode [2];
  logic        rf_we [2], rf_waddr_sel [2], rf_wdata_sel [2], alu_src [2];
  logic [2:0]  alu_op [2];
  logic [1:0]  ext_mode [2];
  logic        dm_req [2], dm_we [2], illegal_instr [2], bus_error [2];
`ifdef MULTI_CYCLE_CONTROL_PERF_EN
  logic [31:0] perf_cycles [2], perf_retired [2];
  int          mcyc [2], mret [2];
`endif

  int n_chk = 0;
  int n_fail = 0;
  int pcw_seen;

  always #5 clk = ~clk;

  multi_cycle_control #(.ALU_OP_W(3), .MEM_TIMEOUT(0), .TMO_CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr(instr[0]), .im_ready(im_ready[0]),
    .dm_ready(dm_ready[0]), .alu_zero(alu_zero[0]), .state(state[0]),
    .im_req(im_req[0]), .ir_write(ir_write[0]), .pc_write(pc_write[0]),
    .npc_mode(npc_mode[0]), .rf_we(rf_we[0]), .rf_waddr_sel(rf_waddr_sel[0]),
    .rf_wdata_sel(rf_wdata_sel[0]), .alu_src(alu_src[0]), .alu_op(alu_op[0]),
    .ext_mode(ext_mode[0]), .dm_req(dm_req[0]), .dm_we(dm_we[0]),
    .illegal_instr(illegal_instr[0]), .bus_error(bus_error[0])
`ifdef MULTI_CYCLE_CONTROL_PERF_EN
    , .perf_cycles(perf_cycles[0]), .perf_retired(perf_retired[0])
`endif
  );

  multi_cycle_control #(.ALU_OP_W(3), .MEM_TIMEOUT(4), .TMO_CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr(instr[1]), .im_ready(im_ready[1]),
    .dm_ready(dm_ready[1]), .alu_zero(alu_zero[1]), .state(state[1]),
    .im_req(im_req[1]), .ir_write(ir_write[1]), .pc_write(pc_write[1]),
    .npc_mode(npc_mode[1]), .rf_we(rf_we[1]), .rf_waddr_sel(rf_waddr_sel[1]),
    .rf_wdata_sel(rf_wdata_sel[1]), .alu_src(alu_src[1]), .alu_op(alu_op[1]),
    .ext_mode(ext_mode[1]), .dm_req(dm_req[1]), .dm_we(dm_we[1]),
    .illegal_instr(illegal_instr[1]), .bus_error(bus_error[1])
`ifdef MULTI_CYCLE_CONTROL_PERF_EN
    , .perf_cycles(perf_cycles[1]), .perf_retired(perf_retired[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
    end
  endtask

  function automatic kind_t kind_of(input logic [31:0] i);
    case (i[31:26])
      6'h00:   kind_of = (i == 32'h0) ? K_NOP : (i[5:0] == 6'h21) ? K_ADDU :
                         (i[5:0] == 6'h23) ? K_SUBU : K_ILL;
      6'h0D:   kind_of = K_ORI;
      6'h0F:   kind_of = K_LUI;
      6'h23:   kind_of = K_LW;
      6'h2B:   kind_of = K_SW;
      6'h04:   kind_of = K_BEQ;
      6'h02:   kind_of = K_J;
      default: kind_of = K_ILL;
    endcase
  endfunction

  // Zero-wait latency of each instruction class.
  function automatic int base_lat(input kind_t k);
    case (k)
      K_J, K_NOP, K_ILL: base_lat = 2;
      K_BEQ:             base_lat = 3;
      K_LW:              base_lat = 5;
      default:           base_lat = 4;
    endcase
  endfunction

  // ALU/operand selection an instruction needs from EXEC onward.
  function automatic ctl_t alu_ctl(input kind_t k);
    ctl_t e;
    e = '0;
    case (k)
      K_SUBU, K_BEQ: e.alu_op = 3'd1;
      K_ORI:         begin e.alu_src = 1; e.alu_op = 3'd2; end
      K_LUI:         begin e.alu_src = 1; e.alu_op = 3'd2; e.ext = 2'd2; end
      K_LW, K_SW:    begin e.alu_src = 1; e.ext = 2'd1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_ctl(input int d, input ctl_t e);
    chk("state", 32'(state[d]), 32'(e.st));
    chk("im_req", 32'(im_req[d]), 32'(e.im_req));
    chk("ir_write", 32'(ir_write[d]), 32'(e.ir_write));
    chk("pc_write", 32'(pc_write[d]), 32'(e.pcw));
    chk("npc_mode", 32'(npc_mode[d]), 32'(e.npc));
    chk("rf_we", 32'(rf_we[d]), 32'(e.rf_we));
    chk("rf_waddr_sel", 32'(rf_waddr_sel[d]), 32'(e.waddr));
    chk("rf_wdata_sel", 32'(rf_wdata_sel[d]), 32'(e.wdata));
    chk("alu_src", 32'(alu_src[d]), 32'(e.alu_src));
    chk("alu_op", 32'(alu_op[d]), 32'(e.alu_op));
    chk("ext_mode", 32'(ext_mode[d]), 32'(e.ext));
    chk("dm_req", 32'(dm_req[d]), 32'(e.dm_req));
    chk("dm_we", 32'(dm_we[d]), 32'(e.dm_we));
    chk("illegal_instr", 32'(illegal_instr[d]), 32'(e.ill));
    chk("bus_error", 32'(bus_error[d]), 32'(e.berr));
`ifdef MULTI_CYCLE_CONTROL_PERF_EN
    chk("perf_cycles", perf_cycles[d], 32'(mcyc[d]));
    chk("perf_retired", perf_retired[d], 32'(mret[d]));
    if (e.st != 3'd0) mcyc[d]++;
    if (e.pcw && !e.ill && !e.berr) mret[d]++;
`endif
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic noise(input int d);
    im_ready[d] = 1'($urandom);
    dm_ready[d] = 1'($urandom);
    alu_zero[d] = 1'($urandom);
  endtask

  // Asynchronous reset: outputs must clear with no clock edge, stay idle,
  // then both instances step to FETCH on the first edge after release.
  task automatic do_reset();
    rst_n = 1'b0;
`ifdef MULTI_CYCLE_CONTROL_PERF_EN
    for (int i = 0; i < 2; i++) begin mcyc[i] = 0; mret[i] = 0; end
`endif
    #1;
    check_ctl(0, '0); check_ctl(1, '0);
    tick();
    check_ctl(0, '0); check_ctl(1, '0);
    rst_n = 1'b1;
    #1;
    check_ctl(0, '0); check_ctl(1, '0);
    tick();
  endtask

  // Walk one instruction from its first FETCH cycle to completion.
  // fw/mw: not-ready cycles before im_ready/dm_ready rise.
  // abort_at >= 0: reset during that MEM cycle index.
  task automatic run_instr(input int d, input logic [31:0] ins, input int fw,
                           input int mw, input logic az, input int abort_at);
    ctl_t  e;
    kind_t k;
    int    tmo_lim, w, m, n, fw0, mw0;
    bit    tmo_mem, done;
    k = kind_of(ins); tmo_lim = (d == 1) ? 4 : 0;
    fw0 = fw; mw0 = mw; n = 0; pcw_seen = 0; tmo_mem = 0; done = 0;
    w = 0;
    forever begin
      noise(d); instr[d] = $urandom; im_ready[d] = (fw == 0); #1;
      e = '0; e.st = 3'd1; e.im_req = 1;
      if (fw == 0) e.ir_write = 1;
      else if (tmo_lim > 0 && w == tmo_lim) begin e.berr = 1; w = 0; end
      else w++;
      check_ctl(d, e); pcw_seen += int'(pc_write[d]); n++; tick();
      if (fw == 0) break;
      fw--;
    end
    noise(d); instr[d] = ins; #1;
    e = '0; e.st = 3'd2;
    case (k)
      K_J:   begin e.pcw = 1; e.npc = 2'd2; done = 1; end
      K_NOP: begin e.pcw = 1; done = 1; end
      K_ILL: begin e.pcw = 1; e.ill = 1; done = 1; end
      default: ;
    endcase
    check_ctl(d, e); pcw_seen += int'(pc_write[d]); n++; tick();
    if (!done) begin
      noise(d); if (k == K_BEQ) alu_zero[d] = az; #1;
      e = alu_ctl(k); e.st = 3'd3;
      if (k == K_BEQ) begin e.pcw = 1; e.npc = {1'b0, az}; done = 1; end
      check_ctl(d, e); pcw_seen += int'(pc_write[d]); n++; tick();
    end
    if (!done && (k == K_LW || k == K_SW)) begin
      w = 0; m = 0;
      forever begin
        noise(d); dm_ready[d] = (mw == 0); #1;
        e = alu_ctl(k); e.st = 3'd4; e.dm_req = 1; e.dm_we = (k == K_SW);
        if (mw == 0) begin
          if (k == K_SW) begin e.pcw = 1; done = 1; end
        end else if (tmo_lim > 0 && w == tmo_lim) begin
          e.berr = 1; e.pcw = 1; done = 1; tmo_mem = 1;
        end else w++;
        check_ctl(d, e); pcw_seen += int'(pc_write[d]); n++;
        if (m == abort_at) begin
          do_reset();
          return;
        end
        tick(); m++;
        if (mw == 0 || done) break;
        mw--;
      end
    end
    if (!done) begin
      noise(d); #1;
      e = alu_ctl(k); e.st = 3'd5; e.rf_we = 1; e.pcw = 1;
      e.waddr = (k == K_ADDU || k == K_SUBU); e.wdata = (k == K_LW);
      check_ctl(d, e); pcw_seen += int'(pc_write[d]); n++; tick();
    end
    chk("pc_write_per_instr", 32'(pcw_seen), 32'd1);
    if (!tmo_mem)
      chk("latency", 32'(n), 32'(base_lat(k) + fw0 + ((k == K_LW || k == K_SW) ? mw0 : 0)));
  endtask

  logic [31:0] pool [12] = '{32'h00221821, 32'h00221823, 32'h3422ABCD, 32'h3C021234,
                             32'h8C040008, 32'hAC040008, 32'h10210004, 32'h08000010,
                             32'h00000000, 32'hFC000000, 32'h00221820, 32'h20420001};

  task automatic rand_instrs(input int d, input int cnt, input int maxw);
    logic [31:0] ins;
    for (int i = 0; i < cnt; i++) begin
      ins = pool[$urandom_range(11, 0)];
      if (ins != 32'h0) ins = ins ^ {6'b0, 20'($urandom), 6'b0};
      run_instr(d, ins, $urandom_range(maxw, 0), $urandom_range(maxw, 0), 1'($urandom), -1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr[i] = '0; im_ready[i] = 0; dm_ready[i] = 0; alu_zero[i] = 0;
`ifdef MULTI_CYCLE_CONTROL_PERF_EN
      mcyc[i] = 0; mret[i] = 0;
`endif
    end
    #2;
    do_reset();
    // MEM_TIMEOUT = 0 instance
    run_instr(0, 32'h00221821, 0, 0, 0, -1);   // addu
    run_instr(0, 32'h8C040008, 0, 3, 0, -1);   // lw, 3 dm waits
    run_instr(0, 32'h10210004, 0, 0, 1, -1);   // beq taken
    run_instr(0, 32'h10210004, 0, 0, 0, -1);   // beq not taken
    run_instr(0, 32'h08000010, 0, 0, 0, -1);   // j
    run_instr(0, 32'hFC000000, 0, 0, 0, -1);   // illegal
    run_instr(0, 32'h00000000, 2, 0, 0, -1);   // nop, 2 im waits
    run_instr(0, 32'h8C040008, 0, 12, 0, -1);  // long wait, no timeout
    rand_instrs(0, 40, 3);
    run_instr(0, 32'hAC040008, 0, 5, 0, 1);    // reset during sw MEM
    run_instr(0, 32'h00221821, 0, 0, 0, -1);
    do_reset();
    // MEM_TIMEOUT = 4 instance
    im_ready[0] = 0;
    run_instr(1, 32'hAC040008, 0, 50, 0, -1);  // sw, dm stuck -> bus_error
    run_instr(1, 32'hAC040008, 0, 4, 0, -1);   // ready on 5th MEM cycle wins
    run_instr(1, 32'h8C040008, 0, 50, 0, -1);  // lw timeout, no WB
    run_instr(1, 32'h00221821, 7, 0, 0, -1);   // fetch timeout then retry
    run_instr(1, 32'h3C021234, 4, 0, 0, -1);   // im ready on 5th fetch cycle
    rand_instrs(1, 40, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
